// File: rtl/div_pkg.sv
// div_pkg: shared types for the divider request scheduler.
// Request/response bundles and scheduler states.
package div_pkg;

   localparam int unsigned DIV_WORD_W = 8;
   localparam int unsigned DIV_TAG_W  = 4;

   typedef enum logic [1:0] {
      IDLE_S,
      ISSUE_S,
      WAIT_S,
      OUT_S
   } sched_state_t;

   typedef struct packed {
      logic [DIV_TAG_W-1:0]  tag;
      logic [DIV_WORD_W-1:0] dividend;
      logic [DIV_WORD_W-1:0] divisor;
   } div_req_t;

   typedef struct packed {
      logic [DIV_TAG_W-1:0]  tag;
      logic [DIV_WORD_W-1:0] quotient;
      logic [DIV_WORD_W-1:0] remainder;
      logic                  dbz;
   } div_rsp_t;

endpackage

// File: rtl/div_req_fifo.sv
// div_req_fifo: synchronous request FIFO with occupancy count.
// Pointers wrap naturally; the count disambiguates full from empty.
module div_req_fifo
   import div_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  div_req_t      din_i,
   input  logic          pop_i,
   output div_req_t      dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   fill_o
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   div_req_t        mem_q [DEPTH];
   logic [AW-1:0]   wr_q;
   logic [AW-1:0]   rd_q;
   logic [AW:0]     cnt_q;
   logic            do_push;
   logic            do_pop;

   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign fill_o  = cnt_q;
   assign dout_o  = mem_q[rd_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/div_req_sched.sv
// div_req_sched: buffers divide requests and sequences them through
// the restoring divider one at a time, resolving divide-by-zero locally.
module div_req_sched
   import div_pkg::*;
#(
   parameter int unsigned WORD_W = DIV_WORD_W,
   parameter int unsigned TAG_W  = DIV_TAG_W,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     s_valid_i,
   output logic                     s_ready_o,
   input  logic [WORD_W-1:0]        s_dividend_i,
   input  logic [WORD_W-1:0]        s_divisor_i,
   input  logic [TAG_W-1:0]         s_tag_i,
   output logic                     div_start_o,
   output logic [WORD_W-1:0]        div_dividend_o,
   output logic [WORD_W-1:0]        div_divisor_o,
   input  logic                     div_ready_i,
   input  logic                     div_valid_i,
   input  logic [WORD_W-1:0]        div_quotient_i,
   input  logic [WORD_W-1:0]        div_reminder_i,
   output logic                     m_valid_o,
   input  logic                     m_ready_i,
   output logic [WORD_W-1:0]        m_quotient_o,
   output logic [WORD_W-1:0]        m_remainder_o,
   output logic [TAG_W-1:0]         m_tag_o,
   output logic                     m_dbz_o,
   output logic [$clog2(DEPTH):0]   fill_o
);

   sched_state_t      state_q;
   div_req_t          req_in;
   div_req_t          head;
   div_rsp_t          rsp_q;
   logic [TAG_W-1:0]  tag_q;
   logic [WORD_W-1:0] dvd_q;
   logic [WORD_W-1:0] dvs_q;
   logic              full;
   logic              empty;
   logic              head_dbz;
   logic              pop;

   assign req_in   = '{tag: s_tag_i, dividend: s_dividend_i,
                       divisor: s_divisor_i};
   assign s_ready_o = !full;
   assign head_dbz = (head.divisor == '0);
   // Zero divisors bypass the divider, so they need not wait for it.
   assign pop = (state_q == IDLE_S) && !empty &&
                (head_dbz || div_ready_i);

   div_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (s_valid_i && s_ready_o),
      .din_i   (req_in),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .fill_o  (fill_o)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE_S;
         rsp_q   <= '0;
         tag_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE_S: begin
               if (pop && head_dbz) begin
                  rsp_q   <= '{tag: head.tag, quotient: '1,
                               remainder: head.dividend, dbz: 1'b1};
                  state_q <= OUT_S;
               end else if (pop) begin
                  dvd_q   <= head.dividend;
                  dvs_q   <= head.divisor;
                  tag_q   <= head.tag;
                  state_q <= ISSUE_S;
               end
            end
            ISSUE_S: state_q <= WAIT_S;
            WAIT_S: begin
               if (div_valid_i) begin
                  rsp_q   <= '{tag: tag_q, quotient: div_quotient_i,
                               remainder: div_reminder_i, dbz: 1'b0};
                  state_q <= OUT_S;
               end
            end
            OUT_S: begin
               if (m_ready_i) state_q <= IDLE_S;
            end
         endcase
      end
   end

   assign div_start_o    = (state_q == ISSUE_S);
   assign div_dividend_o = dvd_q;
   assign div_divisor_o  = dvs_q;
   assign m_valid_o      = (state_q == OUT_S);
   assign m_quotient_o   = rsp_q.quotient;
   assign m_remainder_o  = rsp_q.remainder;
   assign m_tag_o        = rsp_q.tag;
   assign m_dbz_o        = rsp_q.dbz;

endmodule
